// File: rtl/mux_scan_seq.sv
// N-channel, W-bit registered multiplexer with a valid/ready output slot.
// Manual mode selects one channel per cycle; scan mode walks the latched enable mask once.
module mux_scan_seq #(
  parameter int N_CH  = 16,
  parameter int W     = 8,
  parameter int SEL_W = 4   // must equal $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   din,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                start,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                sel_err
);

  // Output handshake: a beat transfers on any edge where out_valid && out_ready.
  // Once raised, out_valid/out_data/out_ch hold until that transfer happens.

  localparam int PW = SEL_W + 1;  // pointer needs one extra bit so N_CH means exhausted

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [N_CH-1:0]   mask;
  logic [W-1:0]      ch [N_CH];
  logic              found;
  logic [SEL_W-1:0]  nxt;
  logic              sel_ok;
  logic              slot_free;

  always_comb begin
    for (int k = 0; k < N_CH; k++) ch[k] = din[k*W +: W];
  end

  // Lowest enabled channel at or above the pointer; descending loop so the lowest wins.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (mask[j] && (PW'(j) >= ptr)) begin
        found = 1'b1;
        nxt   = SEL_W'(j);
      end
    end
  end

  assign sel_ok    = ({1'b0, sel} < PW'(N_CH));
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      mask      <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      // An accepted beat retires unless a capture below replaces it.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!mode) begin
            if (!sel_ok) begin
              sel_err <= 1'b1;
            end else if (slot_free) begin
              out_data  <= ch[sel];
              out_ch    <= sel;
              out_valid <= 1'b1;
            end
          end else if (start) begin
            mask <= ch_en;
            ptr  <= '0;
            if (ch_en == '0) begin
              done <= 1'b1;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (found) begin
            if (slot_free) begin
              out_data  <= ch[nxt];
              out_ch    <= nxt;
              out_valid <= 1'b1;
              ptr       <= PW'(nxt) + PW'(1);
            end
          end else if (slot_free) begin
            // Mask exhausted and the last beat is leaving (or already gone).
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: a 16-channel instance for manual/scan/reset
// and a 12-channel instance for out-of-range selects.
module tb_mux_scan_seq;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int N2 = 12;
  localparam int BW = SW + W;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0]  din;
  logic            mode, start, out_ready;
  logic [SW-1:0]   sel;
  logic [N-1:0]    ch_en;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid, busy, done, sel_err;

  logic [N2*W-1:0] din_b;
  logic            mode_b, start_b, out_ready_b;
  logic [SW-1:0]   sel_b;
  logic [N2-1:0]   ch_en_b;
  logic [W-1:0]    out_data_b;
  logic [SW-1:0]   out_ch_b;
  logic            out_valid_b, busy_b, done_b, sel_err_b;

  mux_scan_seq #(.N_CH(N), .W(W), .SEL_W(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel(sel),
    .ch_en(ch_en), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .sel_err(sel_err)
  );

  mux_scan_seq #(.N_CH(N2), .W(W), .SEL_W(SW)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .din(din_b), .mode(mode_b), .sel(sel_b),
    .ch_en(ch_en_b), .start(start_b), .out_data(out_data_b), .out_ch(out_ch_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b),
    .done(done_b), .sel_err(sel_err_b)
  );

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge; outputs are sampled
  // there or at the falling edge, never on the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // scoreboard: every handshake on the 16-channel instance pops one expected beat
  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      hs_cnt++;
      check("beat_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 32'({out_ch, out_data}), 32'(e));
      end
    end
  end

  initial begin
    int busy_cnt, done_cnt, hs0;

    rst_n = 1'b0; mode = 1'b1; sel = '0; ch_en = '0; start = 1'b0; out_ready = 1'b1;
    mode_b = 1'b1; sel_b = '0; ch_en_b = '0; start_b = 1'b0; out_ready_b = 1'b1;
    for (int k = 0; k < N; k++)  din[k*W +: W]   = 8'(16 + k);
    for (int k = 0; k < N2; k++) din_b[k*W +: W] = 8'(8'hA0 + k);

    #1;
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_sel_err",   32'(sel_err),   32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // manual: one-clock latency, then a full select sweep
    mode = 1'b0; sel = 4'd9;
    exp_q.push_back({4'd9, 8'h19});
    tick();
    check("man_lat_data",  32'(out_data),  32'h19);
    check("man_lat_ch",    32'(out_ch),    32'd9);
    check("man_lat_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < N; k++) begin
      sel = SW'(k);
      exp_q.push_back({4'(k), 8'(16 + k)});
      tick();
      check("man_sweep_data", 32'(out_data), 32'(16 + k));
    end
    mode = 1'b1;
    tick();
    check("man_valid_drop", 32'(out_valid), 32'd0);
    check("man_queue_empty", 32'(exp_q.size()), 32'd0);

    // scan, all channels, full throughput
    ch_en = 16'hFFFF; start = 1'b1;
    for (int k = 0; k < N; k++) exp_q.push_back({4'(k), 8'(16 + k)});
    tick();
    start = 1'b0;
    busy_cnt = int'(busy); done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    // entry edge plus 16 capture edges; busy falls on the edge accepting beat 15
    check("full_busy_cycles", 32'(busy_cnt), 32'd17);
    check("full_done_pulses", 32'(done_cnt), 32'd1);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // sparse mask with a 3-cycle stall on the second beat; ignored inputs toggled mid-scan
    ch_en = 16'h8421;
    exp_q.push_back({4'd0,  8'h10});
    exp_q.push_back({4'd5,  8'h15});
    exp_q.push_back({4'd10, 8'h1A});
    exp_q.push_back({4'd15, 8'h1F});
    hs0 = hs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sparse_first_ch", 32'(out_ch), 32'd0);
    tick();
    check("sparse_second_ch", 32'(out_ch), 32'd5);
    out_ready = 1'b0; mode = 1'b0; sel = 4'd3; start = 1'b1; ch_en = 16'hFFFF;
    din[5*W +: W] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ch",    32'(out_ch),    32'd5);
      check("stall_data",  32'(out_data),  32'h15);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_busy",  32'(busy),      32'd1);
    end
    start = 1'b0; mode = 1'b1; ch_en = 16'h8421; din[5*W +: W] = 8'h15; out_ready = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check("sparse_handshakes", 32'(hs_cnt - hs0), 32'd4);
    check("sparse_done",       32'(done_cnt),     32'd1);
    check("sparse_queue_empty", 32'(exp_q.size()), 32'd0);

    // empty mask: no scan, done on the following cycle
    ch_en = '0; start = 1'b1;
    tick();
    check("empty_busy",  32'(busy),      32'd0);
    check("empty_done",  32'(done),      32'd1);
    check("empty_valid", 32'(out_valid), 32'd0);
    start = 1'b0;
    tick();
    check("empty_done_clear", 32'(done), 32'd0);

    // asynchronous reset while a beat is held mid-scan
    out_ready = 1'b0; ch_en = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_data",  32'(out_data),  32'd0);
    check("async_rst_ch",    32'(out_ch),    32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy",  32'(busy),      32'd0);
    check("async_rst_done",  32'(done),      32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      done_cnt += int'(done);
    end
    check("aborted_no_done", 32'(done_cnt),  32'd0);
    check("aborted_idle",    32'(out_valid), 32'd0);

    // 12-channel instance: out-of-range select leaves the output alone
    mode_b = 1'b0; sel_b = 4'd2;
    tick();
    check("n12_data",  32'(out_data_b),  32'hA2);
    check("n12_valid", 32'(out_valid_b), 32'd1);
    mode_b = 1'b1;
    tick();
    check("n12_drop", 32'(out_valid_b), 32'd0);
    mode_b = 1'b0; sel_b = 4'd13;
    tick();
    check("oor_sel_err", 32'(sel_err_b),   32'd1);
    check("oor_valid",   32'(out_valid_b), 32'd0);
    check("oor_data",    32'(out_data_b),  32'hA2);
    mode_b = 1'b1;
    tick();
    check("oor_pulse_end", 32'(sel_err_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
